mem_bus_bridge: RTL
===================

MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: extra stall cycles inserted before every memory access (range 0-15).
REQ-002 Parameter ADDR_WIDTH, default 10: word-address width of the attached RAM.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 read, write  input  1 each  CPU-side bus read and write requests.
REQ-006 address  input  32  CPU byte address; word index = address[ADDR_WIDTH+1:2], other bits ignored.
REQ-007 byteenable  input  4  byte lanes for writes; ignored for reads.
REQ-008 writedata  input  32  CPU write data.
REQ-009 readdata  output  32  registered read result.
REQ-010 waitrequest  output  1  stall to CPU.
REQ-011 mem_en, mem_we  output  1 / 4  RAM enable and per-byte write strobes.
REQ-012 mem_addr, mem_wdata  output  ADDR_WIDTH / 32  RAM word address and write data.
REQ-013 mem_rdata  input  32  RAM read data, valid exactly one cycle after a cycle with mem_en=1 and mem_we=0.
REQ-014 bus_err  output  1  sticky protocol-error flag.

Function
REQ-015 States: IDLE, WAIT, ACCESS, RESP, DONE.
REQ-016 waitrequest SHALL be combinational: (read|write) AND state!=DONE.
REQ-017 IDLE: on read XOR write, latch op, word address, byteenable and writedata; load counter with WAIT_CYCLES; go WAIT if WAIT_CYCLES>0, else ACCESS.
REQ-018 WAIT: decrement counter each cycle; on the cycle the counter is 1, go ACCESS.
REQ-019 ACCESS: one cycle with mem_en=1, mem_addr/mem_wdata from latches, mem_we=latched byteenable for writes, 0 for reads; read goes RESP, write goes DONE.
REQ-020 RESP: load readdata from mem_rdata at end of cycle; go DONE.
REQ-021 DONE: one cycle, waitrequest low; then IDLE unconditionally.
REQ-022 Read latency: request first seen in IDLE cycle 0 -> waitrequest low in cycle WAIT_CYCLES+3; write: cycle WAIT_CYCLES+2.
REQ-023 Outside ACCESS: mem_en=0, mem_we=0.
REQ-024 read and write both high in IDLE: set bus_err, no RAM access, go directly to DONE, readdata unchanged.
REQ-025 Inputs changing after capture SHALL not affect the in-flight transaction.
REQ-026 Request dropped before DONE: latched transaction still completes (RAM written/read as latched); DONE then returns to IDLE.
REQ-027 Write with byteenable=0: ACCESS occurs with mem_we=0 and no RAM effect; handshake completes normally.
REQ-028 Back-to-back: request held high in DONE is not re-captured; it is re-captured in the following IDLE cycle (one dead cycle, waitrequest high).
REQ-029 bus_err clears only on reset.

Reset
REQ-030 While reset=0: state=IDLE, counter=0, readdata=0, bus_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-031 Reset asserted mid-transaction aborts it immediately; no RAM write may occur in any cycle with reset=0 or after release unless a new request is captured.
REQ-032 After release, first capture occurs on the first rising edge with reset=1 and a valid request.

Verification
REQ-033 WAIT_CYCLES=2, write 0xDEADBEEF to address 0x0000_0010, byteenable=4'b1111 -> mem_we=4'hF, mem_addr=4 in cycle 3; waitrequest low in cycle 4.
REQ-034 Then read address 0x0000_0010 -> readdata=0xDEADBEEF, waitrequest low in cycle 5.
REQ-035 Write 0x11223344 with byteenable=4'b0101 to word 4, then read -> 0xDE22BE44.
REQ-036 WAIT_CYCLES=0, read -> waitrequest low in cycle 3; read and write both high -> bus_err=1, waitrequest low in cycle 1, no mem_en.
REQ-037 Write in WAIT, reset pulled low for one cycle -> mem_we never asserted, readdata=0, state IDLE.
REQ-038 Read dropped during WAIT -> mem_en pulses once in ACCESS, readdata updated, return to IDLE, waitrequest stays low.

Source files
------------

// File: rtl/mem_bus_bridge_if.sv
// mem_bus_bridge_if: CPU-side request/response bus of the memory bridge.
interface mem_bus_bridge_if;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    modport master (output read, write, address, byteenable, writedata, input readdata, waitrequest);
    modport slave (input read, write, address, byteenable, writedata, output readdata, waitrequest);
endinterface

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: stalls CPU bus requests for WAIT_CYCLES, then performs one
// single-cycle access to a synchronous RAM with one-cycle read latency.
module mem_bus_bridge #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_bus_bridge_if.slave       bus,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  bus_err
);
    typedef enum logic [2:0] {IDLE, WAIT, ACCESS, RESP, DONE} state_t;
    state_t     state;
    logic [3:0] cnt;
    logic       op_wr;
    logic [3:0] be;
    logic       unused_addr;
    assign unused_addr = ^{bus.address[31:ADDR_WIDTH+2], bus.address[1:0]};
    assign bus.waitrequest = (bus.read | bus.write) && state != DONE;
    // mem_addr/mem_wdata double as the transaction latches; mem_en/mem_we are
    // raised on entry to ACCESS so they are registered yet aligned to it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            op_wr        <= 1'b0;
            be           <= '0;
            bus.readdata <= '0;
            bus_err      <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= '0;
            case (state)
                IDLE: begin
                    if (bus.read ^ bus.write) begin
                        op_wr     <= bus.write;
                        be        <= bus.byteenable;
                        mem_addr  <= bus.address[ADDR_WIDTH+1:2];
                        mem_wdata <= bus.writedata;
                        cnt       <= 4'(WAIT_CYCLES);
                        state     <= WAIT_CYCLES == 0 ? ACCESS : WAIT;
                        mem_en    <= WAIT_CYCLES == 0;
                        mem_we    <= WAIT_CYCLES == 0 && bus.write ? bus.byteenable : 4'h0;
                    end else if (bus.read & bus.write) begin
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end
                end
                WAIT: begin
                    cnt    <= cnt - 4'd1;
                    state  <= cnt == 4'd1 ? ACCESS : WAIT;
                    mem_en <= cnt == 4'd1;
                    mem_we <= cnt == 4'd1 && op_wr ? be : 4'h0;
                end
                ACCESS: state <= op_wr ? DONE : RESP;
                RESP: begin
                    bus.readdata <= mem_rdata;
                    state        <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
